// File: rtl/mod_subtractor.sv
// mod_subtractor
// ----------------------------------------------------------------------------
// Multi-cycle modular subtractor: diff = (a - b) mod p, processed one LIMB-bit
// limb per clock. A first pass computes a - b limb by limb with a rippling
// borrow. If the final borrow is set, the raw difference wrapped below zero,
// so a second pass adds p back limb by limb. The final carry of that pass is
// dropped, which folds the result back into 0..p-1.
//
// `DATAWIDTH and `FIELD_P are the shared field values supplied to the field
// arithmetic blocks. The guarded fallbacks below only apply when they have
// not already been defined in this compilation.
//
// Ports
//   clk         : single clock; all state changes on its rising edge
//   rst_n       : asynchronous, active-low reset
//   enable      : start request; accepted in IDLE or DONE
//   a           : minuend, expected in 0..p-1
//   b           : subtrahend, expected in 0..p-1
//   busy        : high while an operation is in flight
//   outputReady : high while diff holds a completed result
//   diff        : (a - b) mod p; updated only when a result completes
// ----------------------------------------------------------------------------

`ifndef DATAWIDTH
`define DATAWIDTH 64
`endif
`ifndef FIELD_P
`define FIELD_P 64'hFFFF_FFFF_0000_0001
`endif

module mod_subtractor #(
    parameter int LIMB = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [`DATAWIDTH-1:0] a,
    input  logic [`DATAWIDTH-1:0] b,
    output logic                  busy,
    output logic                  outputReady,
    output logic [`DATAWIDTH-1:0] diff
);

    localparam int W     = `DATAWIDTH;
    localparam int NLIMB = W / LIMB;
    localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    localparam logic [IW-1:0] LASTIDX = IW'(NLIMB - 1);
    localparam logic [W-1:0]  PMOD    = W'(`FIELD_P);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] CORR = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] limbIdx;
    logic          chain;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [W-1:0]  work;

    logic [LIMB-1:0] limbA;
    logic [LIMB-1:0] limbB;
    logic [LIMB-1:0] limbW;
    logic [LIMB-1:0] limbP;
    logic [LIMB:0]   subExt;
    logic [LIMB:0]   addExt;
    logic [LIMB-1:0] limbRes;
    logic            chainOut;
    logic [W-1:0]    workNext;
    logic            isLast;
    int              limbSel;

    // Datapath for the current limb. The borrow (SUB) or carry (CORR) lives
    // in one shared bit, since only one pass is active at a time. Both passes
    // are done in LIMB+1 bits: in the subtraction the extra top bit is set
    // exactly when the limb result went negative, so it is the borrow-out. In
    // the addition it is the carry-out. workNext is the working register with
    // the current limb replaced, so the last limb can go to diff on the same
    // edge that finishes the operation.
    always_comb begin
        limbSel  = int'(limbIdx) * LIMB;
        limbA    = opA[limbSel +: LIMB];
        limbB    = opB[limbSel +: LIMB];
        limbW    = work[limbSel +: LIMB];
        limbP    = PMOD[limbSel +: LIMB];
        subExt   = {1'b0, limbA} - {1'b0, limbB} - {{LIMB{1'b0}}, chain};
        addExt   = {1'b0, limbW} + {1'b0, limbP} + {{LIMB{1'b0}}, chain};
        limbRes  = subExt[LIMB-1:0];
        chainOut = subExt[LIMB];
        if (state == CORR) begin
            limbRes  = addExt[LIMB-1:0];
            chainOut = addExt[LIMB];
        end
        workNext = work;
        workNext[limbSel +: LIMB] = limbRes;
        isLast   = (limbIdx == LASTIDX);
    end

    // Control FSM and state registers. Operands are captured only in IDLE or
    // DONE, so a and b may change freely once an operation has started, and
    // an enable seen during SUB or CORR is ignored. diff is written only on
    // the finishing edge, so partially built limbs are never visible on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            limbIdx     <= '0;
            chain       <= 1'b0;
            opA         <= '0;
            opB         <= '0;
            work        <= '0;
            diff        <= '0;
            busy        <= 1'b0;
            outputReady <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (enable) begin
                        opA         <= a;
                        opB         <= b;
                        limbIdx     <= '0;
                        chain       <= 1'b0;
                        state       <= SUB;
                        outputReady <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SUB: begin
                    work <= workNext;
                    if (isLast) begin
                        limbIdx <= '0;
                        chain   <= 1'b0;
                        if (chainOut) begin
                            state <= CORR;
                        end else begin
                            state       <= DONE;
                            diff        <= workNext;
                            outputReady <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end else begin
                        limbIdx <= limbIdx + IW'(1);
                        chain   <= chainOut;
                    end
                end
                CORR: begin
                    work <= workNext;
                    if (isLast) begin
                        limbIdx     <= '0;
                        chain       <= 1'b0;
                        state       <= DONE;
                        diff        <= workNext;
                        outputReady <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        limbIdx <= limbIdx + IW'(1);
                        chain   <= chainOut;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
